cube_scan_driver: RTL and testbench
===================================

# cube_scan_driver

Parametrised, double-buffered layer-multiplexing driver for an N×N×N LED cube. Accepts a full generation of cell states from the Conway simulator through a valid/ack handshake. Scans the cube one layer at a time, with a programmable dwell and a blanking gap between layers. Presents one-hot layer drive and per-layer column data to the pin-level output stage, and swaps to a new generation only on frame boundaries, so a displayed frame is never torn.

## Interface
Parameters:
- N, 8, cube edge length; cell vector is N*N*N bits, column vector N*N bits
- DWELL, 4096, clocks each layer is driven (≥1)
- BLANK, 16, clocks all outputs dark between layers (≥1)

Ports:
- Clk  input  1  system clock; all logic on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Enable  input  1  scan enable; low forces outputs dark
- Cells  input  N*N*N  generation data; bit index z*N*N + y*N + x, 1 = lit
- FrameValid  input  1  producer asserts while Cells holds a new generation
- FrameAck  output  1  one-cycle pulse: Cells captured into shadow buffer
- Layer  output  N  one-hot layer drive, bit z = layer z, active high
- Columns  output  N*N  column drive for active layer, bit y*N+x, active high
- FrameStart  output  1  one-cycle pulse on first DRIVE cycle of layer 0

## Operation
- Storage: shadow buffer (N*N*N), display buffer (N*N*N), Pending flag (shadow holds an undisplayed frame).
- Capture: when FrameValid=1 and FrameAck not asserted in the previous cycle, and (Pending=0 or a swap occurs this cycle), shadow <= Cells, Pending <= 1, FrameAck = 1 next cycle. Producer holds Cells stable and FrameValid high until it sees FrameAck; it drops FrameValid the cycle after the ack. If Pending=1 and no swap occurs, FrameValid waits (back-pressure).
- Swap: at each frame boundary (entry to BLANK for layer 0), if Pending=1: display <= shadow, Pending <= 0. If capture and swap coincide, display gets the old shadow, shadow gets the new Cells, and Pending stays 1.
- FSM states: IDLE, BLANK, DRIVE. Counters: layer index z (0..N-1), dwell/blank counter.
  - IDLE: outputs dark, z=0. Enable=1 -> BLANK (frame boundary, swap check).
  - BLANK: Layer=0, Columns=0 for BLANK clocks -> DRIVE.
  - DRIVE: Layer=one-hot(z), Columns=display[z*N*N +: N*N] for DWELL clocks. Then z=N-1 -> z=0, BLANK (frame boundary). Otherwise z+1, BLANK.
  - Enable=0 in any state -> IDLE next cycle. Shadow, display and Pending are retained. Captures continue in IDLE.
- Counter widths: clog2 of max(DWELL,BLANK) and of N. No wrap other than z returning to 0 after N-1.

## Timing
- Reset values: Layer=0, Columns=0, FrameAck=0, FrameStart=0, state IDLE, z=0, both buffers all-zero, Pending=0.
- All outputs registered. Capture-to-FrameAck latency: 1 clock.
- Layer period = BLANK+DWELL clocks. Frame period = N*(BLANK+DWELL) clocks.
- Enable rise at cycle t: BLANK during t+1..t+BLANK. First DRIVE (FrameStart=1) at t+BLANK+1.
- Layer and Columns change on the same edge. Layer is never nonzero while Columns shows another layer's data.
- Reset_n assertion mid-frame clears everything immediately. Operation resumes from IDLE after deassertion.

## Test plan
- N=2, DWELL=4, BLANK=2, Cells=8'b1010_0110, FrameValid pulse then Enable=1 -> FrameAck 1 cycle after capture. Layer 2'b01 with Columns 4'b0110 for 4 clocks, 2 dark clocks, then Layer 2'b10 with Columns 4'b1010. Frame period 12 clocks.
- New frame 8'hFF presented mid-frame (during layer 1) -> acked immediately. Layer 1 still shows 4'b1010. Next layer-0 DRIVE shows 4'b1111.
- Two frames back-to-back with no boundary between them -> second FrameValid held with no FrameAck until the frame boundary. Ack arrives 1 cycle after the boundary swap.
- Capture coinciding exactly with the swap cycle -> display takes the old shadow, Pending remains 1, and the new data is shown after the following boundary.
- Enable dropped during DRIVE of layer 1 -> Layer=0, Columns=0 next cycle. On re-enable, restarts at layer 0 after 2 blank clocks, and FrameStart pulses.
- Reset_n pulsed low mid-DRIVE -> all outputs 0 asynchronously. Display all-zero until a new frame is captured and swapped.

Source files
------------

// File: rtl/cube_scan_driver.sv
// cube_scan_driver: double-buffered layer-multiplexing driver for an N x N x N LED cube.
// A new generation is captured into a shadow buffer through a valid/ack handshake.
// It is copied into the display buffer only at frame boundaries, so a shown frame never tears.
// The cube is scanned one layer at a time. Each layer is driven for DWELL clocks,
// and the outputs are held dark for BLANK clocks before every layer.
module cube_scan_driver #(
    parameter int N     = 8,
    parameter int DWELL = 4096,
    parameter int BLANK = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic [N*N*N-1:0] Cells,
    input  logic             FrameValid,
    output logic             FrameAck,
    output logic [N-1:0]     Layer,
    output logic [N*N-1:0]   Columns,
    output logic             FrameStart
);

    localparam int CELLS = N * N * N;
    localparam int COLS  = N * N;
    localparam int MAXC  = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int ZW    = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [ZW-1:0]    z;
    logic [CELLS-1:0] shadow;
    logic [CELLS-1:0] display;
    logic             pending;

    logic             blank_done;
    logic             drive_done;
    logic             last_layer;
    logic             boundary;
    logic             swap;
    logic             capture;
    logic [COLS-1:0]  layer_cols;
    logic [N-1:0]     layer_hot;

    // Frame boundary, swap and capture decisions for the coming edge.
    always_comb begin
        blank_done = (state == S_BLANK) && (cnt == CW'(BLANK - 1));
        drive_done = (state == S_DRIVE) && (cnt == CW'(DWELL - 1));
        last_layer = (z == ZW'(N - 1));
        boundary   = Enable && ((state == S_IDLE) || (drive_done && last_layer));
        swap       = boundary && pending;
        capture    = FrameValid && !FrameAck && (!pending || boundary);
    end

    // Select the active layer's column slice and its one-hot drive pattern.
    always_comb begin
        layer_cols = '0;
        layer_hot  = '0;
        for (int i = 0; i < N; i++) begin
            if (z == ZW'(i)) begin
                layer_cols   = display[i*COLS +: COLS];
                layer_hot[i] = 1'b1;
            end
        end
    end

    // Shadow/display double buffer and the producer handshake.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow   <= '0;
            display  <= '0;
            pending  <= 1'b0;
            FrameAck <= 1'b0;
        end else begin
            FrameAck <= capture;
            if (swap) begin
                display <= shadow;
            end
            if (capture) begin
                shadow  <= Cells;
                pending <= 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end
        end
    end

    // Scan FSM with registered layer and column outputs that always change together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            z          <= '0;
            Layer      <= '0;
            Columns    <= '0;
            FrameStart <= 1'b0;
        end else begin
            FrameStart <= 1'b0;
            if (!Enable) begin
                state   <= S_IDLE;
                cnt     <= '0;
                z       <= '0;
                Layer   <= '0;
                Columns <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_BLANK;
                        cnt   <= '0;
                        z     <= '0;
                    end
                    S_BLANK: begin
                        if (blank_done) begin
                            state      <= S_DRIVE;
                            cnt        <= '0;
                            Layer      <= layer_hot;
                            Columns    <= layer_cols;
                            FrameStart <= (z == '0);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_DRIVE: begin
                        if (drive_done) begin
                            state   <= S_BLANK;
                            cnt     <= '0;
                            Layer   <= '0;
                            Columns <= '0;
                            z       <= last_layer ? '0 : z + ZW'(1);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        z       <= '0;
                        Layer   <= '0;
                        Columns <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cube_scan_driver.sv
// tb_cube_scan_driver: table-driven check of the cube scan driver with N=2, DWELL=4, BLANK=2.
// Each table row holds the inputs for one clock and the outputs expected just after that edge.
module tb_cube_scan_driver;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    typedef struct {
        logic       en;
        logic       fv;
        logic [7:0] cells;
        logic       ack;
        logic [1:0] layer;
        logic [3:0] cols;
        logic       fs;
    } vec_t;

    typedef struct {
        logic       ack;
        logic [1:0] layer;
        logic [3:0] cols;
        logic       fs;
        int         idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       frame_valid = 1'b0;
    logic [7:0] cells = 8'h00;
    logic       frame_ack;
    logic [1:0] layer;
    logic [3:0] columns;
    logic       frame_start;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   split = 0;

    cube_scan_driver #(.N(2), .DWELL(4), .BLANK(2)) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .Enable    (enable),
        .Cells     (cells),
        .FrameValid(frame_valid),
        .FrameAck  (frame_ack),
        .Layer     (layer),
        .Columns   (columns),
        .FrameStart(frame_start)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic add_vec(input int n, input logic en, input logic fv, input logic [7:0] c,
                           input logic ack, input logic [1:0] l, input logic [3:0] col,
                           input logic fs);
        vec_t v;
        v = '{en, fv, c, ack, l, col, fs};
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic compare(input string name, input int idx, input logic [7:0] got,
                           input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        enable      = v.en;
        frame_valid = v.fv;
        cells       = v.cells;
        e = '{v.ack, v.layer, v.cols, v.fs, idx};
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            compare("ack", e.idx, 8'(frame_ack), 8'(e.ack));
            compare("layer", e.idx, 8'(layer), 8'(e.layer));
            compare("columns", e.idx, 8'(columns), 8'(e.cols));
            compare("frame_start", e.idx, 8'(frame_start), 8'(e.fs));
        end
    endtask

    task automatic check_dark(input string name);
        compare({name, "_ack"}, -1, 8'(frame_ack), 8'h00);
        compare({name, "_layer"}, -1, 8'(layer), 8'h00);
        compare({name, "_columns"}, -1, 8'(columns), 8'h00);
        compare({name, "_start"}, -1, 8'(frame_start), 8'h00);
    endtask

    // Pull reset low in the middle of a DRIVE cycle and expect outputs to clear without a clock.
    task automatic reset_mid_drive();
        frame_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_dark("async_reset");
        @(posedge clk);
        #1 check_dark("held_reset");
        rst_n = 1'b1;
    endtask

    initial begin
        // Producer hands over 8'b1010_0110, then scanning is enabled.
        add_vec(1, OFF, ON,  8'hA6, ON,  2'b00, 4'b0000, OFF);
        add_vec(1, OFF, ON,  8'hA6, OFF, 2'b00, 4'b0000, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(1, ON,  OFF, 8'h00, OFF, 2'b01, 4'b0110, ON);
        add_vec(3, ON,  OFF, 8'h00, OFF, 2'b01, 4'b0110, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(4, ON,  OFF, 8'h00, OFF, 2'b10, 4'b1010, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(1, ON,  OFF, 8'h00, OFF, 2'b01, 4'b0110, ON);
        add_vec(3, ON,  OFF, 8'h00, OFF, 2'b01, 4'b0110, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        // 8'hFF arrives while layer 1 is lit: acked at once, shown from the next frame.
        add_vec(1, ON,  ON,  8'hFF, ON,  2'b10, 4'b1010, OFF);
        add_vec(1, ON,  ON,  8'hFF, OFF, 2'b10, 4'b1010, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b10, 4'b1010, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(1, ON,  OFF, 8'h00, OFF, 2'b01, 4'b1111, ON);
        // 8'h3C captured, then 8'hC3 back-pressured until it lands on the swap edge.
        add_vec(1, ON,  ON,  8'h3C, ON,  2'b01, 4'b1111, OFF);
        add_vec(1, ON,  ON,  8'h3C, OFF, 2'b01, 4'b1111, OFF);
        add_vec(1, ON,  OFF, 8'h00, OFF, 2'b01, 4'b1111, OFF);
        add_vec(2, ON,  ON,  8'hC3, OFF, 2'b00, 4'b0000, OFF);
        add_vec(4, ON,  ON,  8'hC3, OFF, 2'b10, 4'b1111, OFF);
        add_vec(1, ON,  ON,  8'hC3, ON,  2'b00, 4'b0000, OFF);
        add_vec(1, ON,  ON,  8'hC3, OFF, 2'b00, 4'b0000, OFF);
        add_vec(1, ON,  OFF, 8'h00, OFF, 2'b01, 4'b1100, ON);
        add_vec(3, ON,  OFF, 8'h00, OFF, 2'b01, 4'b1100, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(4, ON,  OFF, 8'h00, OFF, 2'b10, 4'b0011, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(1, ON,  OFF, 8'h00, OFF, 2'b01, 4'b0011, ON);
        add_vec(3, ON,  OFF, 8'h00, OFF, 2'b01, 4'b0011, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(1, ON,  OFF, 8'h00, OFF, 2'b10, 4'b1100, OFF);
        // Enable dropped during layer 1, then restored.
        add_vec(2, OFF, OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(1, ON,  OFF, 8'h00, OFF, 2'b01, 4'b0011, ON);
        split = vecs.size();
        // After a mid-drive reset the display is blank until 8'h5A is captured and swapped in.
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(1, ON,  OFF, 8'h00, OFF, 2'b01, 4'b0000, ON);
        add_vec(1, ON,  ON,  8'h5A, ON,  2'b01, 4'b0000, OFF);
        add_vec(1, ON,  ON,  8'h5A, OFF, 2'b01, 4'b0000, OFF);
        add_vec(1, ON,  OFF, 8'h00, OFF, 2'b01, 4'b0000, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(4, ON,  OFF, 8'h00, OFF, 2'b10, 4'b0000, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(1, ON,  OFF, 8'h00, OFF, 2'b01, 4'b1010, ON);
        add_vec(3, ON,  OFF, 8'h00, OFF, 2'b01, 4'b1010, OFF);
        add_vec(2, ON,  OFF, 8'h00, OFF, 2'b00, 4'b0000, OFF);
        add_vec(1, ON,  OFF, 8'h00, OFF, 2'b10, 4'b0101, OFF);

        repeat (2) @(posedge clk);
        #1 check_dark("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == split) reset_mid_drive();
            applyStimulus(vecs[i], i);
            @(posedge clk);
            #1 checkOutput();
        end

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
